// File: rtl/mux_n_pipe_pkg.sv
// mux_n_pipe_pkg: shared defaults and helper for the selecting pipeline stage
package mux_n_pipe_pkg;
  localparam int DATA_WIDTH_DEF    = 16;
  localparam int ERR_CNT_WIDTH_DEF = 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/mux_n_pipe_skid_buf.sv
// skid_buf: two-entry main+skid pipeline register with registered ready
module skid_buf import mux_n_pipe_pkg::*; #(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_in_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_out_ready
);
  logic                  r_main_v, r_skid_v, r_rdy;
  logic [DATA_WIDTH-1:0] r_main, r_skid;
  logic                  w_acc, w_pop, w_main_v_n, w_skid_v_n, w_load_main, w_load_skid, w_from_skid;

  assign w_acc      = i_valid & r_rdy;
  assign w_pop      = r_main_v & i_out_ready;
  assign o_in_ready = r_rdy;
  assign o_valid    = r_main_v;
  assign o_data     = r_main_v ? r_main : '0;

  // Decide where an accepted word lands and whether skid refills main
  always_comb begin
    w_main_v_n  = r_main_v;
    w_skid_v_n  = r_skid_v;
    w_load_main = 1'b0;
    w_load_skid = 1'b0;
    w_from_skid = 1'b0;
    if (w_pop) begin
      if (r_skid_v) begin
        w_from_skid = 1'b1;
        w_skid_v_n  = 1'b0;
      end else begin
        w_main_v_n  = w_acc;
        w_load_main = w_acc;
      end
    end else if (w_acc) begin
      if (r_main_v) begin
        w_skid_v_n  = 1'b1;
        w_load_skid = 1'b1;
      end else begin
        w_main_v_n  = 1'b1;
        w_load_main = 1'b1;
      end
    end
  end

  // Storage plus ready flag; ready resets low so acceptance starts one cycle after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_rdy    <= 1'b0;
      r_main   <= '0;
      r_skid   <= '0;
    end else begin
      r_main_v <= w_main_v_n;
      r_skid_v <= w_skid_v_n;
      r_rdy    <= ~w_skid_v_n;
      r_main   <= w_from_skid ? r_skid : w_load_main ? i_data : r_main;
      r_skid   <= w_load_skid ? i_data : r_skid;
    end
  end
endmodule

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way valid/ready channel select into a skid-buffered output with sel error tracking
module mux_n_pipe import mux_n_pipe_pkg::*; #(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int NUM_IN        = 4,
  parameter int SEL_WIDTH     = clog2(NUM_IN),
  parameter int ERR_CNT_WIDTH = ERR_CNT_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SEL_WIDTH-1:0]         sel,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]        o,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic                         sel_err,
  output logic [ERR_CNT_WIDTH-1:0]     err_cnt,
  input  logic                         err_clr
);
  logic                     w_sel_ok, w_rdy;
  logic [DATA_WIDTH-1:0]    w_data;
  logic                     r_sel_err;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

  assign w_sel_ok = {1'b0, sel} < (SEL_WIDTH + 1)'(NUM_IN);
  assign w_data   = in_data[sel*DATA_WIDTH +: DATA_WIDTH];
  assign in_ready = (w_rdy & w_sel_ok) ? NUM_IN'(1) << sel : '0;
  assign sel_err  = r_sel_err;
  assign err_cnt  = r_err_cnt;

  skid_buf #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_data     (w_data),
    .i_valid    (w_sel_ok & in_valid[sel]),
    .o_in_ready (w_rdy),
    .o_data     (o),
    .o_valid    (o_valid),
    .i_out_ready(o_ready)
  );

  // Flag and saturating count of out-of-range select cycles; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_sel_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_sel_err <= ~w_sel_ok;
      r_err_cnt <= (!w_sel_ok && r_err_cnt != '1) ? r_err_cnt + ERR_CNT_WIDTH'(1) : r_err_cnt;
    end
  end
endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: randomized and directed checks of mux_n_pipe against a queue model
module tb_mux_n_pipe;
  logic clk = 1'b0, rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  sel4;
  logic [63:0] in_data4;
  logic [3:0]  in_valid4, in_ready4;
  logic [15:0] o4;
  logic        o_valid4, o_ready4, sel_err4, err_clr4;
  logic [7:0]  err_cnt4;

  logic [1:0]  sel3;
  logic [47:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [15:0] o3;
  logic        o_valid3, o_ready3, sel_err3, err_clr3;
  logic [3:0]  err_cnt3;

  mux_n_pipe #(.DATA_WIDTH(16), .NUM_IN(4), .ERR_CNT_WIDTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .sel(sel4), .in_data(in_data4), .in_valid(in_valid4),
    .in_ready(in_ready4), .o(o4), .o_valid(o_valid4), .o_ready(o_ready4),
    .sel_err(sel_err4), .err_cnt(err_cnt4), .err_clr(err_clr4));

  mux_n_pipe #(.DATA_WIDTH(16), .NUM_IN(3), .ERR_CNT_WIDTH(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .sel(sel3), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .o(o3), .o_valid(o_valid3), .o_ready(o_ready3),
    .sel_err(sel_err3), .err_cnt(err_cnt3), .err_clr(err_clr3));

  int checks = 0, passed = 0;
  logic [15:0] mq[$];
  logic [15:0] outq[$];
  bit m_live = 1'b0;

  function automatic logic [3:0] exp_ready();
    return (m_live && mq.size() < 2) ? 4'b0001 << sel4 : 4'b0000;
  endfunction

  function automatic logic [15:0] exp_o();
    return mq.size() != 0 ? mq[0] : 16'h0000;
  endfunction

  task automatic tick();
    bit fi, fo;
    logic [15:0] w;
    fo = mq.size() != 0 && o_ready4;
    fi = m_live && mq.size() < 2 && in_valid4[sel4];
    w  = in_data4[sel4*16 +: 16];
    @(posedge clk);
    if (rst_n) begin
      if (fo) outq.push_back(mq.pop_front());
      if (fi) mq.push_back(w);
      m_live = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mq.delete();
    m_live = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sel4 = 2'd2; in_valid4 = 4'hF; in_data4 = 64'h1111_2222_3333_4444; o_ready4 = 1'b1; err_clr4 = 1'b0;
    sel3 = 2'd3; in_valid3 = 3'h7; in_data3 = 48'h5555_6666_7777; o_ready3 = 1'b1; err_clr3 = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({in_ready4, o_valid4, o4, sel_err4, err_cnt4} !== 30'd0)
      $display("FAIL reset4 got ready=%b valid=%b o=%h err=%b cnt=%h want all zero", in_ready4, o_valid4, o4, sel_err4, err_cnt4);
    else passed++;
    checks++;
    if ({in_ready3, o_valid3, o3, sel_err3, err_cnt3} !== 25'd0)
      $display("FAIL reset3 got ready=%b valid=%b o=%h err=%b cnt=%h want all zero", in_ready3, o_valid3, o3, sel_err3, err_cnt3);
    else passed++;
    mq.delete();
    m_live = 1'b0;
    in_valid4 = 4'h0; in_valid3 = 3'h0; sel3 = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    do_reset();
    sel4 = 2'd2; in_valid4 = 4'b0100; in_data4 = {16'h0D0D, 16'hA5A5, 16'h0B0B, 16'h0A0A}; o_ready4 = 1'b1;
    #1;
    checks++;
    if (in_ready4 !== 4'b0000) $display("FAIL basic_first_cycle_ready got %b want 0000", in_ready4);
    else passed++;
    tick();
    checks++;
    if ({in_ready4, o_valid4} !== {4'b0100, 1'b0}) $display("FAIL basic_ready got %b/%b want 0100/0", in_ready4, o_valid4);
    else passed++;
    tick();
    checks++;
    if ({o_valid4, o4} !== {1'b1, 16'hA5A5}) $display("FAIL basic_out got %b/%h want 1/a5a5", o_valid4, o4);
    else passed++;
    in_valid4 = 4'h0;
    repeat (3) tick();
    checks++;
    if ({in_ready4, o_valid4, o4} !== {exp_ready(), mq.size() != 0, exp_o()})
      $display("FAIL basic_drain got %b/%b/%h want %b/%b/%h", in_ready4, o_valid4, o4, exp_ready(), mq.size() != 0, exp_o());
    else passed++;
  endtask

  task automatic test_stream();
    int nxt;
    bit acc, ok;
    outq.delete();
    nxt = 0;
    sel4 = 2'd1;
    for (int c = 1; c <= 40 && outq.size() < 8; c++) begin
      o_ready4 = !(c >= 3 && c <= 5);
      in_valid4 = nxt < 8 ? 4'b0010 : 4'b0000;
      in_data4[16 +: 16] = 16'(nxt + 1);
      #1;
      checks++;
      if ({in_ready4, o_valid4, o4} !== {exp_ready(), mq.size() != 0, exp_o()})
        $display("FAIL stream_c%0d got %b/%b/%h want %b/%b/%h", c, in_ready4, o_valid4, o4, exp_ready(), mq.size() != 0, exp_o());
      else passed++;
      if (c == 4) begin
        checks++;
        if (in_ready4 !== 4'b0000) $display("FAIL stream_ready_drop got %b want 0000", in_ready4);
        else passed++;
      end
      acc = m_live && mq.size() < 2 && nxt < 8;
      tick();
      if (acc) nxt++;
    end
    ok = outq.size() == 8;
    for (int i = 0; i < outq.size() && i < 8; i++) if (outq[i] !== 16'(i + 1)) ok = 1'b0;
    checks++;
    if (!ok) $display("FAIL stream_order got %p want 1..8", outq);
    else passed++;
    in_valid4 = 4'h0;
    o_ready4 = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_sel_toggle();
    logic [1:0] prev;
    in_data4 = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
    in_valid4 = 4'hF;
    o_ready4 = 1'b1;
    prev = 2'd0;
    for (int i = 0; i < 10; i++) begin
      sel4 = i[0] ? 2'd3 : 2'd0;
      #1;
      checks++;
      if ({in_ready4, o_valid4, o4} !== {exp_ready(), mq.size() != 0, exp_o()})
        $display("FAIL toggle_model_%0d got %b/%b/%h want %b/%b/%h", i, in_ready4, o_valid4, o4, exp_ready(), mq.size() != 0, exp_o());
      else passed++;
      if (i > 0) begin
        checks++;
        if (o4 !== in_data4[prev*16 +: 16]) $display("FAIL toggle_out_%0d got %h want %h", i, o4, in_data4[prev*16 +: 16]);
        else passed++;
      end
      prev = sel4;
      tick();
    end
    in_valid4 = 4'h0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      sel4 = 2'($urandom);
      in_valid4 = 4'($urandom);
      in_data4 = {$urandom, $urandom};
      o_ready4 = ($urandom % 4) != 0;
      #1;
      checks++;
      if ({in_ready4, o_valid4, o4} !== {exp_ready(), mq.size() != 0, exp_o()}) begin
        if (bad < 10) $display("FAIL random_%0d got %b/%b/%h want %b/%b/%h", i, in_ready4, o_valid4, o4, exp_ready(), mq.size() != 0, exp_o());
        bad++;
      end else passed++;
      tick();
    end
  endtask

  task automatic test_reset_full();
    sel4 = 2'd2; in_valid4 = 4'b0100; in_data4 = 64'h0; in_data4[32 +: 16] = 16'h1234; o_ready4 = 1'b0;
    for (int i = 0; i < 6 && mq.size() < 2; i++) tick();
    checks++;
    if ({in_ready4, o_valid4, mq.size() == 2} !== {4'b0000, 1'b1, 1'b1})
      $display("FAIL full_before_reset got ready=%b valid=%b depth=%0d want 0000/1/2", in_ready4, o_valid4, mq.size());
    else passed++;
    rst_n = 1'b0;
    mq.delete();
    m_live = 1'b0;
    #1;
    checks++;
    if ({in_ready4, o_valid4, o4} !== 21'd0) $display("FAIL reset_immediate got %b/%b/%h want 0/0/0", in_ready4, o_valid4, o4);
    else passed++;
    o_ready4 = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({in_ready4, o_valid4} !== {4'b0100, 1'b0}) $display("FAIL release_edge1 got %b/%b want 0100/0", in_ready4, o_valid4);
    else passed++;
    tick();
    checks++;
    if ({o_valid4, o4} !== {1'b1, 16'h1234}) $display("FAIL release_edge2 got %b/%h want 1/1234", o_valid4, o4);
    else passed++;
    in_valid4 = 4'h0;
    repeat (3) tick();
  endtask

  task automatic test_err();
    do_reset();
    sel3 = 2'd3; in_valid3 = 3'h7; in_data3 = 48'hAAAA_BBBB_CCCC; o_ready3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready3 !== 3'b000) $display("FAIL err_ready_%0d got %b want 000", i, in_ready3);
      else passed++;
      tick();
    end
    checks++;
    if ({sel_err3, err_cnt3} !== {1'b1, 4'd5}) $display("FAIL err_count got %b/%0d want 1/5", sel_err3, err_cnt3);
    else passed++;
    sel3 = 2'd0; err_clr3 = 1'b1;
    tick();
    err_clr3 = 1'b0;
    checks++;
    if ({sel_err3, err_cnt3, in_ready3} !== {1'b0, 4'd0, 3'b001}) $display("FAIL err_clear got %b/%0d/%b want 0/0/001", sel_err3, err_cnt3, in_ready3);
    else passed++;
  endtask

  task automatic test_sat();
    sel3 = 2'd3;
    repeat (20) tick();
    checks++;
    if ({sel_err3, err_cnt3} !== {1'b1, 4'hF}) $display("FAIL err_saturate got %b/%h want 1/f", sel_err3, err_cnt3);
    else passed++;
    err_clr3 = 1'b1;
    tick();
    err_clr3 = 1'b0;
    checks++;
    if ({sel_err3, err_cnt3} !== {1'b0, 4'h0}) $display("FAIL err_clr_priority got %b/%h want 0/0", sel_err3, err_cnt3);
    else passed++;
    sel3 = 2'd1;
    tick();
    checks++;
    if ({sel_err3, err_cnt3} !== {1'b0, 4'h0}) $display("FAIL err_in_range got %b/%h want 0/0", sel_err3, err_cnt3);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_sel_toggle();
    test_random();
    test_reset_full();
    test_err();
    test_sat();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/mux_n_pipe.md
MUX_N_PIPE -- requirements
Module: mux_n_pipe

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of each data word.
REQ-002 Parameter NUM_IN, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SEL_WIDTH, default $clog2(NUM_IN), width of sel; derived, not overridden.
REQ-004 Parameter ERR_CNT_WIDTH, default 8, width of the error counter.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 sel  input  SEL_WIDTH  channel select, sampled every cycle.
REQ-008 in_data  input  NUM_IN*DATA_WIDTH  packed channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 in_valid  input  NUM_IN  per-channel valid.
REQ-010 in_ready  output  NUM_IN  per-channel ready.
REQ-011 o  output  DATA_WIDTH  selected word.
REQ-012 o_valid  output  1  o holds a word.
REQ-013 o_ready  input  1  downstream accepts o.
REQ-014 sel_err  output  1  registered flag: previous cycle had out-of-range sel.
REQ-015 err_cnt  output  ERR_CNT_WIDTH  saturating count of out-of-range-sel cycles.
REQ-016 err_clr  input  1  synchronous clear of err_cnt and sel_err.

Function
REQ-017 Input transfer on channel i SHALL occur when in_valid[i] and in_ready[i] are both 1 at a rising edge.
REQ-018 in_ready[i] SHALL be 1 only when i == sel, sel < NUM_IN, and the skid slot is empty; combinational from sel and a register, never from in_valid.
REQ-019 Output transfer SHALL occur when o_valid and o_ready are both 1 at a rising edge.
REQ-020 Storage SHALL be a 2-entry skid buffer (main + skid register); latency input transfer to o_valid is exactly 1 cycle.
REQ-021 Sustained throughput SHALL be one word per cycle while o_ready = 1 and the selected channel is valid.
REQ-022 When main is full and o_ready = 0, an accepted word SHALL go to skid; in_ready drops the following cycle.
REQ-023 On output transfer with skid full, skid SHALL move to main; words leave in acceptance order, none lost or duplicated.
REQ-024 Simultaneous input and output transfer with main full and skid empty SHALL load the new word into main directly.
REQ-025 A change of sel SHALL take effect in the same cycle; words already buffered are unaffected.
REQ-026 sel >= NUM_IN (non-power-of-two NUM_IN only) SHALL force all in_ready to 0, set sel_err next cycle, and increment err_cnt once per such cycle.
REQ-027 err_cnt SHALL saturate at all-ones; err_clr SHALL zero err_cnt and sel_err next cycle and has priority over increment.
REQ-028 o SHALL hold main-register contents; when o_valid = 0, o SHALL be all zeros.

Reset
REQ-029 rst_n low SHALL immediately clear main, skid, their valid bits, sel_err and err_cnt; o = 0, o_valid = 0, in_ready = 0.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered words; no transfer completes that cycle.
REQ-031 in_ready SHALL be driven by a registered empty-skid flag so no in_ready is 1 in the first cycle after reset release; acceptance starts in the second.

Structure
REQ-032 Shared package SHALL hold DATA_WIDTH default, the ERR_CNT_WIDTH default and a clog2 helper function.
REQ-033 The skid buffer SHALL be a sub-module named skid_buf, parameterised by DATA_WIDTH, reusable by other pipeline stages.
REQ-034 The input select SHALL be an indexed part-select, no priority chain.

Verification
REQ-035 NUM_IN=4, sel=2, in_valid=4'b0100, in_data ch2=16'hA5A5, o_ready=1 -> o=16'hA5A5, o_valid=1 one cycle later; in_ready=4'b0100.
REQ-036 Stream 8 words on ch1 with o_ready low for cycles 3-5 -> in_ready low from cycle 4, output order 1..8 intact, no loss.
REQ-037 NUM_IN=3, sel=2'b11 for 5 cycles -> in_ready=0, sel_err=1, err_cnt=5; pulse err_clr -> err_cnt=0, sel_err=0.
REQ-038 sel toggles 0->3 every cycle, all channels valid with distinct data, o_ready=1 -> o alternates ch0/ch3 data, 1-cycle latency.
REQ-039 rst_n pulsed low with both buffer entries full -> o_valid=0, o=0 immediately; first new word emerges 2 cycles after release.
REQ-040 ERR_CNT_WIDTH=4, out-of-range sel for 20 cycles -> err_cnt stops at 4'hF.
